button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz); the number of consecutive cycles a synchronized input must differ from its debounced level before the level changes; legal range 2 to 2^24.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: btn_reset  input  1  raw, asynchronous, bouncing reset push-button (1 = pressed).
REQ-005 Port: btn_trig  input  1  raw, asynchronous, bouncing start/stop push-button.
REQ-006 Port: btn_split  input  1  raw, asynchronous, bouncing split/clear push-button.
REQ-007 Port: reset_o  output  1  one-cycle pulse on a debounced press of btn_reset; feeds the control FSM's reset input.
REQ-008 Port: trig_o  output  1  one-cycle pulse on a debounced press of btn_trig; feeds the control FSM's trig input.
REQ-009 Port: split_o  output  1  one-cycle pulse on a debounced press of btn_split; feeds the control FSM's split input.
REQ-010 Port: btn_level  output  3  debounced levels {split, trig, reset}, bit 0 = reset channel.

Function
REQ-011 Each of the three channels SHALL be an independent, identical instance of a synchronizer, debounce counter and edge detector; no state is shared except clk and reset.
REQ-012 Synchronizer: two flip-flops in series per raw input; only the second flip-flop output (sync) SHALL be used downstream.
REQ-013 Debounce counter: width ceil(log2(DEBOUNCE_CYCLES)) bits, unsigned; it SHALL clear whenever sync equals the debounced level.
REQ-014 While sync differs from the debounced level, the counter SHALL increment by 1 each cycle.
REQ-015 On a cycle where sync differs and the counter equals DEBOUNCE_CYCLES-1, the debounced level SHALL take the value of sync and the counter SHALL clear; the counter SHALL never wrap.
REQ-016 Any single cycle of sync equal to the debounced level (a bounce) SHALL restart the count from 0.
REQ-017 Pulse: the channel's pulse output SHALL be registered and asserted for exactly one cycle, in the cycle immediately after the debounced level goes 0->1.
REQ-018 A debounced release (1->0) SHALL update btn_level and SHALL NOT produce a pulse.
REQ-019 Latency: raw input stable high from sampling edge k -> debounced level and pulse high after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges from first sample.
REQ-020 Holding a button indefinitely SHALL produce exactly one pulse (no auto-repeat).
REQ-021 Simultaneous events: if reset_o is asserted in a cycle, trig_o and split_o SHALL be forced to 0 in that cycle; the suppressed pulses are dropped, not deferred.
REQ-022 trig_o and split_o asserted in the same cycle (without reset_o) SHALL both be passed through unmodified; priority between them belongs to the downstream FSM.
REQ-023 btn_level SHALL reflect the debounced level registers directly, with no masking by REQ-021.

Reset
REQ-024 With reset high at a rising edge, all synchronizer flip-flops, debounced levels, counters and pulse registers SHALL clear to 0 at that edge.
REQ-025 During and in the cycle after reset: reset_o = trig_o = split_o = 0 and btn_level = 3'b000.
REQ-026 Reset asserted mid-count SHALL abort the count with no pulse generated.
REQ-027 A button still held when reset deasserts SHALL be treated as a new press: one pulse DEBOUNCE_CYCLES+2 edges after reset release.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 btn_trig 0->1 and held stable -> trig_o high for exactly one cycle, 6 edges after the first sample edge; btn_level[1] = 1 thereafter; no further pulses while held.
REQ-029 btn_split bounces 1,0,1,1,0,1 then held high -> no split_o until 4 consecutive high sync cycles, then exactly one pulse.
REQ-030 btn_reset and btn_trig pressed in the same cycle and held -> reset_o pulses, trig_o stays 0 in that cycle, btn_level = 3'b011.
REQ-031 btn_trig held; reset asserted after 2 counting cycles for 1 cycle -> no trig_o during the aborted count; exactly one trig_o 6 edges after reset release.
REQ-032 Press held, then release held 4+ cycles -> btn_level bit drops after the debounce interval with no pulse; a second press yields a second single pulse.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and conditioned outputs of the button conditioner.
// Button side drives raw levels; conditioner side returns pulses and debounced levels.
interface button_conditioner_if;
  logic       btn_reset;
  logic       btn_trig;
  logic       btn_split;
  logic       reset_o;
  logic       trig_o;
  logic       split_o;
  logic [2:0] btn_level;

  modport master (
    output btn_reset,
    output btn_trig,
    output btn_split,
    input  reset_o,
    input  trig_o,
    input  split_o,
    input  btn_level
  );

  modport slave (
    input  btn_reset,
    input  btn_trig,
    input  btn_split,
    output reset_o,
    output trig_o,
    output split_o,
    output btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Three independent button channels: 2-FF synchronizer, saturating debounce counter and
// rising-edge pulse. The reset-button pulse masks coincident trig/split pulses.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  button_conditioner_if.slave  btn
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Channel order matches btn_level: bit 0 reset, bit 1 trig, bit 2 split.
  logic [2:0] raw;
  logic [2:0] level;
  logic [2:0] pulse;

  assign raw = {btn.btn_split, btn.btn_trig, btn.btn_reset};

  for (genvar g = 0; g < 3; g++) begin : gen_chan
    logic            meta_q;
    logic            sync_q;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      level_d = level_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      if (sync_q != level_q) begin
        if (cnt_q == CntMax) begin
          // Pulse is registered alongside the level so both rise on the same edge.
          level_d = sync_q;
          pulse_d = sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        meta_q  <= 1'b0;
        sync_q  <= 1'b0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        meta_q  <= raw[g];
        sync_q  <= meta_q;
        level_q <= level_d;
        pulse_q <= pulse_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level[g] = level_q;
    assign pulse[g] = pulse_q;
  end

  // A reset press wins outright; masked trig/split pulses are simply lost.
  assign btn.reset_o   = pulse[0];
  assign btn.trig_o    = pulse[1] & ~pulse[0];
  assign btn.split_o   = pulse[2] & ~pulse[0];
  assign btn.btn_level = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4; every cycle compares
// {btn_level, reset_o, trig_o, split_o} against hand-computed values.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  button_conditioner_if ifc ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %b, expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n cycles with the given debounced level and no pulses.
  task automatic expect_idle(input string tag, input logic [2:0] lvl, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s[%0d]", tag, i),
            {ifc.btn_level, ifc.reset_o, ifc.trig_o, ifc.split_o}, {lvl, 3'b000});
    end
  endtask

  task automatic expect_event(input string tag, input logic [2:0] lvl,
                              input logic r, input logic t, input logic s);
    tick();
    check(tag, {ifc.btn_level, ifc.reset_o, ifc.trig_o, ifc.split_o}, {lvl, r, t, s});
  endtask

  logic bounce [6];

  initial begin
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ifc.btn_reset = 1'b0;
    ifc.btn_trig  = 1'b0;
    ifc.btn_split = 1'b0;
    reset = 1'b1;

    tick();
    tick();
    check("reset_hold", {ifc.btn_level, ifc.reset_o, ifc.trig_o, ifc.split_o}, 6'b000000);
    reset = 1'b0;
    expect_idle("reset_after", 3'b000, 1);

    // Clean press: pulse 6 edges after first sample, no repeat while held.
    ifc.btn_trig = 1'b1;
    expect_idle("trig_wait", 3'b000, 5);
    expect_event("trig_pulse", 3'b010, 1'b0, 1'b1, 1'b0);
    expect_idle("trig_hold", 3'b010, 10);
    ifc.btn_trig = 1'b0;
    expect_idle("trig_rel_wait", 3'b010, 5);
    expect_idle("trig_rel_done", 3'b000, 4);

    // Second press gives a second single pulse.
    ifc.btn_trig = 1'b1;
    expect_idle("trig2_wait", 3'b000, 5);
    expect_event("trig2_pulse", 3'b010, 1'b0, 1'b1, 1'b0);
    expect_idle("trig2_hold", 3'b010, 3);
    ifc.btn_trig = 1'b0;
    expect_idle("trig2_rel_wait", 3'b010, 5);
    expect_idle("trig2_rel_done", 3'b000, 3);

    // Bouncing split: last low sample at edge 5, stable from edge 6, pulse after edge 11.
    for (int j = 0; j < 6; j++) begin
      ifc.btn_split = bounce[j];
      tick();
      check($sformatf("split_bounce[%0d]", j),
            {ifc.btn_level, ifc.reset_o, ifc.trig_o, ifc.split_o}, 6'b000000);
    end
    expect_idle("split_wait", 3'b000, 4);
    expect_event("split_pulse", 3'b100, 1'b0, 1'b0, 1'b1);
    expect_idle("split_hold", 3'b100, 3);
    ifc.btn_split = 1'b0;
    expect_idle("split_rel_wait", 3'b100, 5);
    expect_idle("split_rel_done", 3'b000, 2);

    // Reset and trig together: trig pulse masked, level unmasked.
    ifc.btn_reset = 1'b1;
    ifc.btn_trig  = 1'b1;
    expect_idle("rt_wait", 3'b000, 5);
    expect_event("rt_pulse", 3'b011, 1'b1, 1'b0, 1'b0);
    expect_idle("rt_hold", 3'b011, 3);
    ifc.btn_reset = 1'b0;
    ifc.btn_trig  = 1'b0;
    expect_idle("rt_rel_wait", 3'b011, 5);
    expect_idle("rt_rel_done", 3'b000, 2);

    // Trig and split together both pass through.
    ifc.btn_trig  = 1'b1;
    ifc.btn_split = 1'b1;
    expect_idle("ts_wait", 3'b000, 5);
    expect_event("ts_pulse", 3'b110, 1'b0, 1'b1, 1'b1);
    expect_idle("ts_hold", 3'b110, 2);
    ifc.btn_trig  = 1'b0;
    ifc.btn_split = 1'b0;
    expect_idle("ts_rel_wait", 3'b110, 5);
    expect_idle("ts_rel_done", 3'b000, 2);

    // Reset after two counting cycles aborts; held button re-presses after release.
    ifc.btn_trig = 1'b1;
    expect_idle("abort_count", 3'b000, 4);
    reset = 1'b1;
    expect_idle("abort_reset", 3'b000, 1);
    reset = 1'b0;
    expect_idle("abort_wait", 3'b000, 5);
    expect_event("abort_pulse", 3'b010, 1'b0, 1'b1, 1'b0);
    expect_idle("abort_hold", 3'b010, 3);
    ifc.btn_trig = 1'b0;
    expect_idle("abort_rel_wait", 3'b010, 5);
    expect_idle("abort_rel_done", 3'b000, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
